// File: rtl/scariv_pkg.sv
// Shared core-wide types and sizing for the scariv rename/branch machinery.
package scariv_pkg;

    localparam int unsigned RNID_WIDTH  = 7;
    localparam int unsigned BRU_ENTRIES = 16;
    localparam int unsigned BRTAG_W     = $clog2(BRU_ENTRIES);

    typedef logic [BRTAG_W-1:0]    brtag_t;
    typedef logic [RNID_WIDTH-1:0] rnid_t;

endpackage

// File: rtl/scariv_bru_rn_snapshot_pool_if.sv
// Port bundle between the snapshot pool control and its snapshot storage.
interface scariv_bru_rn_snapshot_pool_if #(
    parameter int unsigned WORD_W   = 224,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned BR_PORTS = 2
);

    localparam int unsigned ADDR_W = $clog2(ENTRIES);

    logic [BR_PORTS-1:0]             wr_en;
    logic [BR_PORTS-1:0][ADDR_W-1:0] wr_addr;
    logic [BR_PORTS-1:0][WORD_W-1:0] wr_data;
    logic [ADDR_W-1:0]               rd_addr;
    logic [WORD_W-1:0]               rd_data;

    modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
    modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);

endinterface

// File: rtl/scariv_bru_rn_snapshot_pool_ram.sv
// Snapshot storage: BR_PORTS write ports, one asynchronous read port.
module scariv_snapshot_ram #(
    parameter int unsigned WORD_W   = 224,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned BR_PORTS = 2
) (
    input logic                          i_clk,
    scariv_bru_rn_snapshot_pool_if.slave ram
);

    logic [WORD_W-1:0] mem_q [ENTRIES];

    // Ports are applied in ascending order so the highest port wins a collision.
    always_ff @(posedge i_clk) begin
        for (int unsigned p = 0; p < BR_PORTS; p++) begin
            if (ram.wr_en[p]) begin
                mem_q[ram.wr_addr[p]] <= ram.wr_data[p];
            end
        end
    end

    assign ram.rd_data = mem_q[ram.rd_addr];

endmodule

// File: rtl/scariv_bru_rn_snapshot_pool.sv
// Rename-map snapshot pool: captures per-branch rename maps at dispatch and
// restores the map of a mispredicted branch one cycle after resolution.
module scariv_bru_rn_snapshot_pool
    import scariv_pkg::*;
#(
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned RNID_W    = RNID_WIDTH,
    parameter int unsigned ENTRIES   = BRU_ENTRIES,
    parameter int unsigned DISP_SIZE = 4,
    parameter int unsigned BR_PORTS  = 2
) (
    input  logic                                        i_clk,
    input  logic                                        i_reset,
    input  logic [ARCH_REGS-1:0][RNID_W-1:0]            i_rn_list,
    input  logic [DISP_SIZE-1:0]                        i_rd_valid,
    input  logic [DISP_SIZE-1:0][$clog2(ARCH_REGS)-1:0] i_rd_archreg,
    input  logic [DISP_SIZE-1:0][RNID_W-1:0]            i_rd_rnid,
    input  logic [DISP_SIZE-1:0]                        i_load,
    input  logic [DISP_SIZE-1:0][$clog2(ENTRIES)-1:0]   i_brtag,
    input  logic                                        i_upd_valid,
    input  logic [$clog2(ENTRIES)-1:0]                  i_upd_brtag,
    input  logic                                        i_upd_mispred,
    input  logic                                        i_flush,
    output logic                                        o_restore_valid,
    output logic [ARCH_REGS-1:0][RNID_W-1:0]            o_rn_list,
    output logic [ENTRIES-1:0]                          o_live,
    output logic [$clog2(ENTRIES+1)-1:0]                o_count,
    output logic                                        o_err
);

    localparam int unsigned TAG_W  = (ENTRIES == BRU_ENTRIES) ? $bits(brtag_t) : $clog2(ENTRIES);
    localparam int unsigned CNT_W  = $clog2(ENTRIES+1);
    localparam int unsigned WORD_W = ARCH_REGS * RNID_W;

    typedef logic [ARCH_REGS-1:0][RNID_W-1:0] map_t;

    map_t                           slot_map [DISP_SIZE];
    logic [BR_PORTS-1:0]            cap_en;
    logic [BR_PORTS-1:0][TAG_W-1:0] cap_tag;
    map_t                           cap_data [BR_PORTS];
    logic                           load_overflow;

    logic                           mispred;
    logic                           kill;
    logic                           cap_err;
    logic [ENTRIES-1:0]             live_d, live_q;
    logic                           restore_valid_d, restore_valid_q;
    map_t                           rn_list_d, rn_list_q;
    logic                           err_d, err_q;
    logic [CNT_W-1:0]               count;

    scariv_bru_rn_snapshot_pool_if #(
        .WORD_W   (WORD_W),
        .ENTRIES  (ENTRIES),
        .BR_PORTS (BR_PORTS)
    ) ram_if ();

    scariv_snapshot_ram #(
        .WORD_W   (WORD_W),
        .ENTRIES  (ENTRIES),
        .BR_PORTS (BR_PORTS)
    ) u_ram (
        .i_clk (i_clk),
        .ram   (ram_if.slave)
    );

    // Per-slot rename map plus rank-ordered assignment of loads to write ports.
    always_comb begin
        map_t        cur;
        int unsigned rank;
        cur      = i_rn_list;
        rank     = 0;
        cap_en   = '0;
        cap_tag  = '0;
        for (int unsigned p = 0; p < BR_PORTS; p++) begin
            cap_data[p] = '0;
        end
        for (int unsigned d = 0; d < DISP_SIZE; d++) begin
            if (i_rd_valid[d]) begin
                cur[i_rd_archreg[d]] = i_rd_rnid[d];
            end
            slot_map[d] = cur;
            if (i_load[d]) begin
                for (int unsigned p = 0; p < BR_PORTS; p++) begin
                    if (rank == p) begin
                        cap_en[p]   = 1'b1;
                        cap_tag[p]  = i_brtag[d];
                        cap_data[p] = cur;
                    end
                end
                rank++;
            end
        end
        load_overflow = (rank > BR_PORTS);
    end

    // Release is applied before captures, so a capture re-arming a just-released tag is legal.
    always_comb begin
        mispred = i_upd_valid & i_upd_mispred;
        kill    = mispred | i_flush;
        live_d  = live_q;
        cap_err = 1'b0;
        if (i_upd_valid && !i_upd_mispred) begin
            live_d[i_upd_brtag] = 1'b0;
        end
        for (int unsigned p = 0; p < BR_PORTS; p++) begin
            if (cap_en[p]) begin
                if (live_d[cap_tag[p]]) begin
                    cap_err = 1'b1;
                end
                live_d[cap_tag[p]] = 1'b1;
            end
        end
        if (kill) begin
            live_d = '0;
        end
        restore_valid_d = mispred & live_q[i_upd_brtag];
        rn_list_d       = restore_valid_d ? map_t'(ram_if.rd_data) : rn_list_q;
        err_d           = load_overflow | (mispred & ~live_q[i_upd_brtag]) | (~kill & cap_err);
    end

    always_comb begin
        count = '0;
        for (int unsigned e = 0; e < ENTRIES; e++) begin
            count = count + CNT_W'(live_q[e]);
        end
    end

    always_comb begin
        ram_if.wr_en   = (kill || i_reset) ? '0 : cap_en;
        ram_if.wr_addr = cap_tag;
        for (int unsigned p = 0; p < BR_PORTS; p++) begin
            ram_if.wr_data[p] = cap_data[p];
        end
        ram_if.rd_addr = i_upd_brtag;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            live_q          <= '0;
            restore_valid_q <= 1'b0;
            rn_list_q       <= '0;
            err_q           <= 1'b0;
        end else begin
            live_q          <= live_d;
            restore_valid_q <= restore_valid_d;
            rn_list_q       <= rn_list_d;
            err_q           <= err_d;
        end
    end

    assign o_live          = live_q;
    assign o_count         = count;
    assign o_restore_valid = restore_valid_q;
    assign o_rn_list       = rn_list_q;
    assign o_err           = err_q;

endmodule

// File: tb/tb_scariv_bru_rn_snapshot_pool.sv
// Bench for the rename snapshot pool: directed scenarios plus random traffic,
// all checked every cycle against a behavioural model of the pool.
module tb_scariv_bru_rn_snapshot_pool;
    import scariv_pkg::*;

    localparam int unsigned ARCH_REGS = 32;
    localparam int unsigned RNID_W    = RNID_WIDTH;
    localparam int unsigned ENTRIES   = BRU_ENTRIES;
    localparam int unsigned DISP_SIZE = 4;
    localparam int unsigned BR_PORTS  = 2;
    localparam int unsigned AR_W      = 5;
    localparam int unsigned TAG_W     = $bits(brtag_t);
    localparam int unsigned CNT_W     = 5;

    typedef logic [ARCH_REGS-1:0][RNID_W-1:0] map_t;

    logic                              clk = 1'b0;
    logic                              rst;
    map_t                              rn_list;
    logic [DISP_SIZE-1:0]              rd_valid;
    logic [DISP_SIZE-1:0][AR_W-1:0]    rd_archreg;
    logic [DISP_SIZE-1:0][RNID_W-1:0]  rd_rnid;
    logic [DISP_SIZE-1:0]              load;
    logic [DISP_SIZE-1:0][TAG_W-1:0]   brtag;
    logic                              upd_valid;
    brtag_t                            upd_brtag;
    logic                              upd_mispred;
    logic                              flush;
    logic                              o_restore_valid;
    map_t                              o_rn_list;
    logic [ENTRIES-1:0]                o_live;
    logic [CNT_W-1:0]                  o_count;
    logic                              o_err;

    scariv_bru_rn_snapshot_pool #(
        .ARCH_REGS (ARCH_REGS),
        .RNID_W    (RNID_W),
        .ENTRIES   (ENTRIES),
        .DISP_SIZE (DISP_SIZE),
        .BR_PORTS  (BR_PORTS)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_rn_list       (rn_list),
        .i_rd_valid      (rd_valid),
        .i_rd_archreg    (rd_archreg),
        .i_rd_rnid       (rd_rnid),
        .i_load          (load),
        .i_brtag         (brtag),
        .i_upd_valid     (upd_valid),
        .i_upd_brtag     (upd_brtag),
        .i_upd_mispred   (upd_mispred),
        .i_flush         (flush),
        .o_restore_valid (o_restore_valid),
        .o_rn_list       (o_rn_list),
        .o_live          (o_live),
        .o_count         (o_count),
        .o_err           (o_err)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;

    map_t               m_snap [ENTRIES];
    logic [ENTRIES-1:0] m_live;
    logic               m_rv;
    logic               m_err;
    map_t               m_rnl;

    function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Model step: derive post-edge state from pre-edge state and current inputs.
    function automatic void model_update();
        map_t maps [DISP_SIZE];
        map_t m;
        int   loads[$];
        int   ntake;
        logic mis;
        brtag_t t;
        m = rn_list;
        for (int d = 0; d < DISP_SIZE; d++) begin
            if (rd_valid[d]) m[rd_archreg[d]] = rd_rnid[d];
            maps[d] = m;
            if (load[d]) loads.push_back(d);
        end
        ntake = (loads.size() > BR_PORTS) ? BR_PORTS : loads.size();
        mis   = upd_valid && upd_mispred;
        if (rst) begin
            m_live = '0;
            m_rv   = 1'b0;
            m_err  = 1'b0;
            m_rnl  = '0;
            return;
        end
        m_err = (loads.size() > BR_PORTS);
        m_rv  = 1'b0;
        if (mis) begin
            if (m_live[upd_brtag]) begin
                m_rv  = 1'b1;
                m_rnl = m_snap[upd_brtag];
            end else begin
                m_err = 1'b1;
            end
        end
        if (mis || flush) begin
            m_live = '0;
        end else begin
            if (upd_valid) m_live[upd_brtag] = 1'b0;
            for (int i = 0; i < ntake; i++) begin
                t = brtag[loads[i]];
                if (m_live[t]) m_err = 1'b1;
                m_live[t] = 1'b1;
                m_snap[t] = maps[loads[i]];
            end
        end
    endfunction

    task automatic step();
        int cnt;
        model_update();
        @(posedge clk);
        #1;
        cnt = 0;
        for (int e = 0; e < ENTRIES; e++) cnt += int'(m_live[e]);
        chk("live", 256'(o_live), 256'(m_live));
        chk("count", 256'(o_count), 256'(cnt));
        chk("restore_valid", 256'(o_restore_valid), 256'(m_rv));
        chk("err", 256'(o_err), 256'(m_err));
        chk("rn_list", 256'(o_rn_list), 256'(m_rnl));
    endtask

    task automatic idle();
        rst         = 1'b0;
        rd_valid    = '0;
        rd_archreg  = '0;
        rd_rnid     = '0;
        load        = '0;
        brtag       = '0;
        upd_valid   = 1'b0;
        upd_brtag   = '0;
        upd_mispred = 1'b0;
        flush       = 1'b0;
        for (int i = 0; i < ARCH_REGS; i++) rn_list[i] = RNID_W'(i);
    endtask

    task automatic mispredict(input int tag);
        idle();
        upd_valid   = 1'b1;
        upd_mispred = 1'b1;
        upd_brtag   = TAG_W'(tag);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        step();
        chk("reset_count", 256'(o_count), 256'd0);
        chk("reset_live", 256'(o_live), 256'd0);

        // Single write then branch in slot 1; restore on mispredict.
        idle();
        rd_valid[0] = 1'b1; rd_archreg[0] = 5'd5; rd_rnid[0] = 7'd40;
        load[1] = 1'b1; brtag[1] = 4'd3;
        step();
        chk("r24_count", 256'(o_count), 256'd1);
        mispredict(3);
        step();
        chk("r24_rv", 256'(o_restore_valid), 256'd1);
        chk("r24_x5", 256'(o_rn_list[5]), 256'd40);
        chk("r24_x4", 256'(o_rn_list[4]), 256'd4);
        chk("r24_x31", 256'(o_rn_list[31]), 256'd31);
        chk("r24_live", 256'(o_live), 256'd0);

        // Later slot overrides earlier on the same arch reg.
        idle();
        rd_valid[0] = 1'b1; rd_archreg[0] = 5'd5; rd_rnid[0] = 7'd40;
        rd_valid[2] = 1'b1; rd_archreg[2] = 5'd5; rd_rnid[2] = 7'd41;
        load[2] = 1'b1; brtag[2] = 4'd1;
        step();
        mispredict(1);
        step();
        chk("r25_x5", 256'(o_rn_list[5]), 256'd41);

        // Three loads with two ports.
        idle();
        load = 4'b0111; brtag[0] = 4'd0; brtag[1] = 4'd1; brtag[2] = 4'd2;
        step();
        chk("r26_live", 256'(o_live), 256'h0003);
        chk("r26_count", 256'(o_count), 256'd2);
        chk("r26_err", 256'(o_err), 256'd1);

        idle(); flush = 1'b1;
        step();
        chk("flush_count", 256'(o_count), 256'd0);
        for (int k = 0; k < 8; k++) begin
            idle();
            load = 4'b0011; brtag[0] = TAG_W'(2*k); brtag[1] = TAG_W'(2*k+1);
            step();
        end
        chk("r27_full", 256'(o_count), 256'd16);
        idle(); upd_valid = 1'b1; upd_brtag = 4'd7;
        step();
        chk("r27_rel", 256'(o_count), 256'd15);
        mispredict(7);
        step();
        chk("r27_err", 256'(o_err), 256'd1);
        chk("r27_rv", 256'(o_restore_valid), 256'd0);
        chk("r27_live", 256'(o_live), 256'd0);

        // Capture discarded by same-cycle mispredict.
        idle(); load[0] = 1'b1; brtag[0] = 4'd2;
        step();
        mispredict(2); load[0] = 1'b1; brtag[0] = 4'd4;
        step();
        chk("r28_rv", 256'(o_restore_valid), 256'd1);
        chk("r28_x9", 256'(o_rn_list[9]), 256'd9);
        chk("r28_live", 256'(o_live), 256'd0);
        mispredict(4);
        step();
        chk("r28_err", 256'(o_err), 256'd1);
        chk("r28_rv2", 256'(o_restore_valid), 256'd0);

        // Release and capture of the same tag in one cycle.
        idle(); load[0] = 1'b1; brtag[0] = 4'd5;
        step();
        idle(); upd_valid = 1'b1; upd_brtag = 4'd5; load[0] = 1'b1; brtag[0] = 4'd5;
        step();
        chk("r16_live5", 256'(o_live[5]), 256'd1);
        chk("r16_err", 256'(o_err), 256'd0);

        // Reset wins over a mispredict.
        idle(); load[0] = 1'b1; brtag[0] = 4'd6;
        step();
        mispredict(6); rst = 1'b1;
        step();
        chk("r29_rv", 256'(o_restore_valid), 256'd0);
        chk("r29_count", 256'(o_count), 256'd0);
        idle();
        step();
        chk("r29_rv2", 256'(o_restore_valid), 256'd0);
        chk("r29_count2", 256'(o_count), 256'd0);

        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) < 2);
            for (int i = 0; i < ARCH_REGS; i++) rn_list[i] = RNID_W'($urandom);
            rd_valid = DISP_SIZE'($urandom);
            load     = DISP_SIZE'($urandom & $urandom);
            for (int d = 0; d < DISP_SIZE; d++) begin
                rd_archreg[d] = AR_W'($urandom);
                rd_rnid[d]    = RNID_W'($urandom);
                brtag[d]      = TAG_W'($urandom);
            end
            upd_valid   = ($urandom_range(0, 99) < 35);
            upd_mispred = ($urandom_range(0, 99) < 25);
            upd_brtag   = TAG_W'($urandom);
            flush       = ($urandom_range(0, 99) < 4);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
